// File: rtl/multi_vc_input_buffer_if.sv
// Link-side and allocator-side signals of the multi-VC input buffer.
// The master drives flits, reads and grants; the slave is the buffer.
interface multi_vc_input_buffer_if #(
  parameter int VC_NUM = 2,
  parameter int DATA_W = 32,
  parameter int PORT_W = 3
);
  localparam int VC_W = $clog2(VC_NUM);

  logic                     wr_en_i;
  logic [VC_W-1:0]          wr_vc_i;
  logic [1:0]               wr_label_i;
  logic [DATA_W-1:0]        wr_data_i;
  logic [PORT_W-1:0]        wr_port_i;
  logic                     rd_en_i;
  logic [VC_W-1:0]          rd_vc_i;
  logic [VC_NUM-1:0]        va_grant_i;
  logic [VC_NUM*VC_W-1:0]   va_vc_i;
  logic [1:0]               rd_label_o;
  logic [DATA_W-1:0]        rd_data_o;
  logic [VC_W-1:0]          rd_vc_o;
  logic [VC_NUM*PORT_W-1:0] out_port_o;
  logic [VC_NUM-1:0]        va_req_o;
  logic [VC_NUM-1:0]        sa_req_o;
  logic [VC_NUM-1:0]        empty_o;
  logic [VC_NUM-1:0]        full_o;
  logic [VC_NUM-1:0]        on_off_o;
  logic [VC_NUM-1:0]        err_o;

  modport master (
    output wr_en_i, wr_vc_i, wr_label_i,
    output wr_data_i, wr_port_i,
    output rd_en_i, rd_vc_i,
    output va_grant_i, va_vc_i,
    input  rd_label_o, rd_data_o, rd_vc_o,
    input  out_port_o, va_req_o, sa_req_o,
    input  empty_o, full_o, on_off_o, err_o
  );

  modport slave (
    input  wr_en_i, wr_vc_i, wr_label_i,
    input  wr_data_i, wr_port_i,
    input  rd_en_i, rd_vc_i,
    input  va_grant_i, va_vc_i,
    output rd_label_o, rd_data_o, rd_vc_o,
    output out_port_o, va_req_o, sa_req_o,
    output empty_o, full_o, on_off_o, err_o
  );
endinterface

// File: rtl/multi_vc_input_buffer.sv
// Input-port storage: one circular flit FIFO per VC, each with
// its own IDLE/VA/SA packet FSM, route, downstream VC and error flag.
module multi_vc_input_buffer #(
  parameter int VC_NUM         = 2,
  parameter int BUFFER_SIZE    = 8,
  parameter int PIPELINE_DEPTH = 5,
  parameter int DATA_W         = 32,
  parameter int PORT_W         = 3
) (
  input logic clk,
  input logic rst,
  multi_vc_input_buffer_if.slave bus
);
  localparam int VC_W  = $clog2(VC_NUM);
  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT =
    CNT_W'(BUFFER_SIZE);
  localparam logic [CNT_W-1:0] ON_CNT =
    CNT_W'(BUFFER_SIZE - PIPELINE_DEPTH);

  localparam logic [1:0] L_HEAD = 2'd0;
  localparam logic [1:0] L_TAIL = 2'd2;
  localparam logic [1:0] L_HT   = 2'd3;

  typedef enum logic [1:0] {IDLE, VA, SA} state_e;

  logic [1:0]        lbl_q [VC_NUM][BUFFER_SIZE];
  logic [DATA_W-1:0] dat_q [VC_NUM][BUFFER_SIZE];
  logic [PORT_W-1:0] prt_q [VC_NUM][BUFFER_SIZE];

  logic [PTR_W-1:0]  rp_q    [VC_NUM];
  logic [PTR_W-1:0]  rp_d    [VC_NUM];
  logic [PTR_W-1:0]  wp_q    [VC_NUM];
  logic [PTR_W-1:0]  wp_d    [VC_NUM];
  logic [CNT_W-1:0]  cnt_q   [VC_NUM];
  logic [CNT_W-1:0]  cnt_d   [VC_NUM];
  state_e            st_q    [VC_NUM];
  state_e            st_d    [VC_NUM];
  logic [PORT_W-1:0] route_q [VC_NUM];
  logic [PORT_W-1:0] route_d [VC_NUM];
  logic [VC_W-1:0]   dvc_q   [VC_NUM];
  logic [VC_W-1:0]   dvc_d   [VC_NUM];
  logic [1:0]        front   [VC_NUM];

  logic [VC_NUM-1:0] err_q, err_d;
  logic [VC_NUM-1:0] wr_hit, rd_hit;
  logic [VC_NUM-1:0] wr_ok, rd_ok;
  logic [VC_NUM-1:0] empty, full;

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      empty[v]  = cnt_q[v] == '0;
      full[v]   = cnt_q[v] == FULL_CNT;
      front[v]  = lbl_q[v][rp_q[v]];
      wr_hit[v] = bus.wr_en_i &&
                  bus.wr_vc_i == VC_W'(v);
      rd_hit[v] = bus.rd_en_i &&
                  bus.rd_vc_i == VC_W'(v);
      wr_ok[v]  = wr_hit[v] && !full[v];
      rd_ok[v]  = rd_hit[v] && !empty[v] &&
                  st_q[v] == SA;
      wp_d[v]   = wr_ok[v] ? wp_q[v] + PTR_W'(1)
                           : wp_q[v];
      rp_d[v]   = rd_ok[v] ? rp_q[v] + PTR_W'(1)
                           : rp_q[v];
      cnt_d[v]  = cnt_q[v] + CNT_W'(wr_ok[v])
                           - CNT_W'(rd_ok[v]);
      err_d[v]  = err_q[v] |
                  (wr_hit[v] & full[v]) |
                  (rd_hit[v] & ~rd_ok[v]);
      st_d[v]    = st_q[v];
      route_d[v] = route_q[v];
      dvc_d[v]   = dvc_q[v];
      unique case (st_q[v])
        IDLE: if (!empty[v]) begin
          if (front[v] == L_HEAD ||
              front[v] == L_HT) begin
            st_d[v]    = VA;
            route_d[v] = prt_q[v][rp_q[v]];
          end else begin
            // stray BODY/TAIL: flag it, wait for reset
            err_d[v] = 1'b1;
          end
        end
        VA: if (bus.va_grant_i[v]) begin
          st_d[v]  = SA;
          dvc_d[v] = bus.va_vc_i[v*VC_W +: VC_W];
        end
        SA: if (rd_ok[v] &&
                (front[v] == L_TAIL ||
                 front[v] == L_HT)) begin
          st_d[v] = IDLE;
        end
        default: st_d[v] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= '0;
      for (int v = 0; v < VC_NUM; v++) begin
        rp_q[v]    <= '0;
        wp_q[v]    <= '0;
        cnt_q[v]   <= '0;
        st_q[v]    <= IDLE;
        route_q[v] <= '0;
        dvc_q[v]   <= '0;
      end
    end else begin
      err_q <= err_d;
      for (int v = 0; v < VC_NUM; v++) begin
        rp_q[v]    <= rp_d[v];
        wp_q[v]    <= wp_d[v];
        cnt_q[v]   <= cnt_d[v];
        st_q[v]    <= st_d[v];
        route_q[v] <= route_d[v];
        dvc_q[v]   <= dvc_d[v];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < VC_NUM; v++) begin
      if (wr_ok[v]) begin
        lbl_q[v][wp_q[v]] <= bus.wr_label_i;
        dat_q[v][wp_q[v]] <= bus.wr_data_i;
        prt_q[v][wp_q[v]] <= bus.wr_port_i;
      end
    end
  end

  always_comb begin
    bus.rd_label_o = front[bus.rd_vc_i];
    bus.rd_data_o  =
      dat_q[bus.rd_vc_i][rp_q[bus.rd_vc_i]];
    bus.rd_vc_o    = dvc_q[bus.rd_vc_i];
    bus.empty_o    = empty;
    bus.full_o     = full;
    bus.err_o      = err_q;
    bus.out_port_o = '0;
    bus.va_req_o   = '0;
    bus.sa_req_o   = '0;
    bus.on_off_o   = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      bus.out_port_o[v*PORT_W +: PORT_W] = route_q[v];
      bus.va_req_o[v] = st_q[v] == VA;
      bus.sa_req_o[v] = st_q[v] == SA && !empty[v];
      bus.on_off_o[v] = cnt_q[v] < ON_CNT;
    end
  end
endmodule

// File: tb/tb_multi_vc_input_buffer.sv
// Directed bench for multi_vc_input_buffer (2 VCs, depth 8, round-trip 5).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_multi_vc_input_buffer;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  localparam logic [31:0] A = 32'hA000_0000;
  localparam logic [31:0] B = 32'hB000_0000;
  localparam logic [31:0] C = 32'hC000_0000;
  localparam logic [31:0] D = 32'hD000_0000;

  multi_vc_input_buffer_if #(
    .VC_NUM(2), .DATA_W(32), .PORT_W(3)
  ) bus ();

  multi_vc_input_buffer #(
    .VC_NUM(2), .BUFFER_SIZE(8),
    .PIPELINE_DEPTH(5), .DATA_W(32), .PORT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input logic vc, input logic [1:0] lbl,
                    input logic [31:0] dat,
                    input logic [2:0] prt);
    bus.wr_en_i    = 1'b1;
    bus.wr_vc_i    = vc;
    bus.wr_label_i = lbl;
    bus.wr_data_i  = dat;
    bus.wr_port_i  = prt;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst = 1'b0;
    bus.wr_en_i = 0; bus.wr_vc_i = 0;
    bus.wr_label_i = 0; bus.wr_data_i = 0;
    bus.wr_port_i = 0; bus.rd_en_i = 0;
    bus.rd_vc_i = 0; bus.va_grant_i = 0;
    bus.va_vc_i = 0;

    // reset with writes pending
    wr(1'b0, 2'd0, 32'hDEAD, 3'd7);
    tick();
    tick();
    chk("rst_empty", 64'(bus.empty_o), 64'h3);
    chk("rst_full", 64'(bus.full_o), 64'h0);
    chk("rst_onoff", 64'(bus.on_off_o), 64'h3);
    chk("rst_vareq", 64'(bus.va_req_o), 64'h0);
    chk("rst_sareq", 64'(bus.sa_req_o), 64'h0);
    chk("rst_err", 64'(bus.err_o), 64'h0);
    chk("rst_port", 64'(bus.out_port_o), 64'h0);
    chk("rst_rdvc", 64'(bus.rd_vc_o), 64'h0);
    bus.wr_en_i = 0;
    rst = 1'b1;
    tick();
    chk("post_rst_empty", 64'(bus.empty_o), 64'h3);
    chk("post_rst_vareq", 64'(bus.va_req_o), 64'h0);

    // HEAD/BODY/TAIL on VC1
    bus.rd_vc_i = 1'b1;
    wr(1'b1, 2'd0, A + 1, 3'd3);
    tick();
    chk("p1_empty", 64'(bus.empty_o), 64'h1);
    chk("p1_vareq_early", 64'(bus.va_req_o), 64'h0);
    chk("p1_front_lbl", 64'(bus.rd_label_o), 64'h0);
    chk("p1_front_dat", 64'(bus.rd_data_o), 64'(A + 1));
    wr(1'b1, 2'd1, A + 2, 3'd0);
    tick();
    chk("p1_vareq", 64'(bus.va_req_o), 64'h2);
    chk("p1_port", 64'(bus.out_port_o), 64'h18);
    wr(1'b1, 2'd2, A + 3, 3'd0);
    tick();
    bus.wr_en_i = 0;
    bus.va_grant_i = 2'b10;
    bus.va_vc_i = 2'b00;
    tick();
    bus.va_grant_i = 0;
    chk("p1_sareq", 64'(bus.sa_req_o), 64'h2);
    chk("p1_vareq_off", 64'(bus.va_req_o), 64'h0);
    chk("p1_rdvc", 64'(bus.rd_vc_o), 64'h0);
    bus.rd_en_i = 1'b1;
    chk("p1_lbl0", 64'(bus.rd_label_o), 64'h0);
    tick();
    chk("p1_lbl1", 64'(bus.rd_label_o), 64'h1);
    chk("p1_dat1", 64'(bus.rd_data_o), 64'(A + 2));
    tick();
    chk("p1_lbl2", 64'(bus.rd_label_o), 64'h2);
    chk("p1_dat2", 64'(bus.rd_data_o), 64'(A + 3));
    tick();
    bus.rd_en_i = 0;
    chk("p1_idle_sa", 64'(bus.sa_req_o), 64'h0);
    chk("p1_idle_va", 64'(bus.va_req_o), 64'h0);
    chk("p1_empty_end", 64'(bus.empty_o), 64'h3);
    chk("p1_err", 64'(bus.err_o), 64'h0);

    // HEADTAIL then HEAD on VC0
    bus.rd_vc_i = 1'b0;
    wr(1'b0, 2'd3, B + 1, 3'd5);
    tick();
    wr(1'b0, 2'd0, B + 2, 3'd2);
    tick();
    bus.wr_en_i = 0;
    chk("ht_vareq", 64'(bus.va_req_o), 64'h1);
    chk("ht_port", 64'(bus.out_port_o), 64'h1D);
    bus.va_grant_i = 2'b01;
    bus.va_vc_i = 2'b01;
    tick();
    bus.va_grant_i = 0;
    bus.va_vc_i = 0;
    chk("ht_sareq", 64'(bus.sa_req_o), 64'h1);
    chk("ht_rdvc", 64'(bus.rd_vc_o), 64'h1);
    chk("ht_lbl", 64'(bus.rd_label_o), 64'h3);
    chk("ht_dat", 64'(bus.rd_data_o), 64'(B + 1));
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 0;
    chk("ht_idle_va", 64'(bus.va_req_o), 64'h0);
    chk("ht_idle_sa", 64'(bus.sa_req_o), 64'h0);
    chk("ht_next_dat", 64'(bus.rd_data_o), 64'(B + 2));
    tick();
    chk("ht_vareq2", 64'(bus.va_req_o), 64'h1);
    chk("ht_port2", 64'(bus.out_port_o), 64'h1A);
    bus.va_grant_i = 2'b01;
    tick();
    bus.va_grant_i = 0;
    chk("ht_rdvc2", 64'(bus.rd_vc_o), 64'h0);
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 0;
    chk("ht_empty", 64'(bus.empty_o), 64'h3);
    chk("ht_sa_empty", 64'(bus.sa_req_o), 64'h0);
    chk("ht_err", 64'(bus.err_o), 64'h0);

    // fill VC0 (held in SA) to full and overflow
    for (int i = 0; i < 8; i++) begin
      wr(1'b0, 2'd1, C + 32'(i), 3'd0);
      tick();
      chk("fill_onoff", 64'(bus.on_off_o[0]),
          64'(i < 2));
    end
    chk("fill_full", 64'(bus.full_o), 64'h1);
    chk("fill_sareq", 64'(bus.sa_req_o), 64'h1);
    wr(1'b0, 2'd1, 32'hBAD, 3'd0);
    tick();
    bus.wr_en_i = 0;
    chk("ovf_err", 64'(bus.err_o), 64'h1);
    chk("ovf_full", 64'(bus.full_o), 64'h1);
    chk("ovf_front", 64'(bus.rd_data_o), 64'(C));
    bus.rd_en_i = 1'b1;
    tick();
    tick();
    tick();
    chk("c5_front", 64'(bus.rd_data_o), 64'(C + 3));
    chk("c5_full", 64'(bus.full_o), 64'h0);
    chk("c5_onoff", 64'(bus.on_off_o), 64'h2);
    wr(1'b0, 2'd1, C + 8, 3'd0);
    tick();
    bus.wr_en_i = 0;
    for (int j = 0; j < 5; j++) begin
      chk("c5_drain", 64'(bus.rd_data_o),
          64'(C + 32'(4 + j)));
      tick();
    end
    bus.rd_en_i = 0;
    chk("c5_empty", 64'(bus.empty_o), 64'h3);
    chk("c5_err", 64'(bus.err_o), 64'h1);

    // 20-flit stream through VC1, pointers wrap
    bus.rd_vc_i = 1'b1;
    wr(1'b1, 2'd0, D, 3'd1);
    tick();
    bus.wr_en_i = 0;
    tick();
    chk("wr_vareq", 64'(bus.va_req_o), 64'h2);
    chk("wr_port", 64'(bus.out_port_o), 64'h0A);
    bus.va_grant_i = 2'b10;
    bus.va_vc_i = 2'b10;
    tick();
    bus.va_grant_i = 0;
    bus.va_vc_i = 0;
    chk("wr_sareq", 64'(bus.sa_req_o), 64'h2);
    chk("wr_rdvc", 64'(bus.rd_vc_o), 64'h1);
    for (int i = 1; i < 20; i++) begin
      wr(1'b1, (i == 19) ? 2'd2 : 2'd1,
         D + 32'(i), 3'd0);
      bus.rd_en_i = 1'b1;
      chk("wrap_dat", 64'(bus.rd_data_o),
          64'(D + 32'(i - 1)));
      tick();
    end
    bus.wr_en_i = 0;
    chk("wrap_last", 64'(bus.rd_data_o), 64'(D + 19));
    chk("wrap_lbl", 64'(bus.rd_label_o), 64'h2);
    tick();
    bus.rd_en_i = 0;
    chk("wrap_empty", 64'(bus.empty_o), 64'h3);
    chk("wrap_idle", 64'(bus.sa_req_o), 64'h0);
    chk("wrap_err", 64'(bus.err_o), 64'h1);

    // protocol errors are per VC
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("e_rst_err", 64'(bus.err_o), 64'h0);
    chk("e_rst_port", 64'(bus.out_port_o), 64'h0);
    bus.rd_en_i = 1'b1;
    tick();
    bus.rd_en_i = 0;
    chk("e_rd_empty", 64'(bus.err_o), 64'h2);
    wr(1'b0, 2'd1, 32'h5, 3'd4);
    tick();
    bus.wr_en_i = 0;
    chk("e_body_wait", 64'(bus.err_o), 64'h2);
    chk("e_body_empty", 64'(bus.empty_o), 64'h2);
    tick();
    chk("e_body_err", 64'(bus.err_o), 64'h3);
    chk("e_body_va", 64'(bus.va_req_o), 64'h0);
    tick();
    chk("e_body_hold", 64'(bus.va_req_o), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
